// File: rtl/mem_bus_pkg.sv
// Shared types and default widths for the memory bus initiator.
package mem_bus_pkg;

  localparam int unsigned DEF_AWIDTH = 5;
  localparam int unsigned DEF_DWIDTH = 8;
  localparam int unsigned DEF_LWIDTH = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWr,
    StRd,
    StRdTail
  } state_e;

endpackage

// File: rtl/mem_initiator_if.sv
// Host-side request/response port of the memory initiator.
interface mem_initiator_if #(
  parameter int unsigned AWIDTH = 5,
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned LWIDTH = 4
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [AWIDTH-1:0] req_addr;
  logic [LWIDTH-1:0] req_len;
  logic [DWIDTH-1:0] req_wdata;
  logic              rsp_valid;
  logic [DWIDTH-1:0] rsp_rdata;
  logic              rsp_last;
  logic              busy;

  // Host side: issues requests, consumes responses.
  modport master (
    output req_valid, req_we, req_addr, req_len, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_last, busy
  );

  // Initiator side.
  modport slave (
    input  req_valid, req_we, req_addr, req_len, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_last, busy
  );

endinterface

// File: rtl/mem_bus_driver.sv
// Registered output-enable and write-data flops driving the shared tri-state data bus.
module mem_bus_driver #(
  parameter int unsigned DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              oe_d,
  input  logic [DWIDTH-1:0] data_d,
  inout  wire  [DWIDTH-1:0] mem_data
);

  logic              oe_q;
  logic [DWIDTH-1:0] data_q;

  // Drive flops; reset releases the bus immediately.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      oe_q   <= 1'b0;
      data_q <= '0;
    end else begin
      oe_q   <= oe_d;
      data_q <= data_d;
    end
  end

  assign mem_data = oe_q ? data_q : {DWIDTH{1'bz}};

endmodule

// File: rtl/mem_initiator.sv
// Bus initiator for a single-port tri-state memory: single writes and burst reads.
module mem_initiator
  import mem_bus_pkg::*;
#(
  parameter int unsigned AWIDTH = DEF_AWIDTH,
  parameter int unsigned DWIDTH = DEF_DWIDTH,
  parameter int unsigned LWIDTH = DEF_LWIDTH
) (
  input  logic              clk,
  input  logic              rst_,
  mem_initiator_if.slave    host,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_wr,
  output logic              mem_rd,
  inout  wire  [DWIDTH-1:0] mem_data
);

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [LWIDTH-1:0] rem_q, rem_d;       // read addresses still to issue after the current one
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic              cap_q, cap_d;       // bus holds a valid read word this cycle
  logic              cap_last_q, cap_last_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_last_q, rsp_last_d;
  logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              drv_oe_d;
  logic [DWIDTH-1:0] drv_data_d;
  logic [DWIDTH-1:0] bus_in;

  assign bus_in = mem_data;

  // Next-state, address/burst counters and registered-output next values.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    drv_oe_d   = 1'b0;
    drv_data_d = '0;
    case (state_q)
      StIdle: begin
        if (host.req_valid && ready_q) begin
          addr_d = host.req_addr;
          if (host.req_we) begin
            state_d    = StWr;
            rem_d      = '0;
            drv_oe_d   = 1'b1;
            drv_data_d = host.req_wdata;
          end else begin
            state_d = StRd;
            rem_d   = host.req_len;
          end
        end
      end
      StWr:     state_d = StIdle;
      StRd: begin
        if (rem_q == '0) begin
          state_d = StRdTail;
        end else begin
          addr_d = addr_q + 1'b1;  // wraps modulo 2**AWIDTH
          rem_d  = rem_q - 1'b1;
        end
      end
      StRdTail: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    ready_d = (state_d == StIdle);
    busy_d  = (state_d != StIdle);
    wr_d    = (state_d == StWr);
    rd_d    = (state_d == StRd) || (state_d == StRdTail);

    // Capture trails address issue by one cycle: memory output register needs a cycle to load.
    cap_d       = (state_q == StRd);
    cap_last_d  = (state_q == StRd) && (rem_q == '0);
    rsp_valid_d = cap_q;
    rsp_last_d  = cap_q && cap_last_q;
    rsp_rdata_d = cap_q ? bus_in : rsp_rdata_q;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      rem_q       <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      cap_q       <= 1'b0;
      cap_last_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cap_q       <= cap_d;
      cap_last_q  <= cap_last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  mem_bus_driver #(
    .DWIDTH (DWIDTH)
  ) u_drv (
    .clk      (clk),
    .rst_     (rst_),
    .oe_d     (drv_oe_d),
    .data_d   (drv_data_d),
    .mem_data (mem_data)
  );

  assign host.req_ready = ready_q;
  assign host.busy      = busy_q;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_last  = rsp_last_q;
  assign host.rsp_rdata = rsp_rdata_q;
  assign mem_addr       = addr_q;
  assign mem_wr         = wr_q;
  assign mem_rd         = rd_q;

endmodule
